// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access controller: FSM state codes, Zicsr funct3
// encodings, merge kinds and the default data/address widths.
package csr_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ADDR_W_DEF = 12;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_READ   = 3'd1;
    localparam state_t ST_CAPT   = 3'd2;
    localparam state_t ST_WRITE  = 3'd3;
    localparam state_t ST_TWRITE = 3'd4;
    localparam state_t ST_RESP   = 3'd5;

    localparam logic [2:0] CSR_OP_RW  = 3'b001;
    localparam logic [2:0] CSR_OP_RS  = 3'b010;
    localparam logic [2:0] CSR_OP_RC  = 3'b011;
    localparam logic [2:0] CSR_OP_RWI = 3'b101;
    localparam logic [2:0] CSR_OP_RSI = 3'b110;
    localparam logic [2:0] CSR_OP_RCI = 3'b111;

    // Top two address bits of a read-only CSR.
    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

    typedef enum logic [1:0] {
        MERGE_RW = 2'd0,
        MERGE_RS = 2'd1,
        MERGE_RC = 2'd2
    } merge_e;

endpackage

// File: rtl/csr_op_decode.sv
// Combinational decode of a Zicsr request into legality, read/write need and merge kind.
// Optional macro: CSR_PRIV_CHECK_EN adds the privilege-level check.
module csr_op_decode
    import csr_pkg::*;
(
    input  logic [2:0] op,
    input  logic [1:0] addr_ro_bits,
`ifdef CSR_PRIV_CHECK_EN
    input  logic [1:0] addr_priv_bits,
    input  logic [1:0] cur_priv,
`endif
    input  logic       rd_zero,
    input  logic       rs1_zero,
    output logic       illegal,
    output logic       do_read,
    output logic       do_write,
    output merge_e     merge
);

    logic bad_op_s;
    logic wr_raw_s;
    logic rd_raw_s;
    logic priv_bad_s;

    // Classify the op, then gate read/write on overall legality.
    always_comb begin
        bad_op_s = 1'b0;
        merge    = MERGE_RW;
        case (op)
            CSR_OP_RW, CSR_OP_RWI: merge = MERGE_RW;
            CSR_OP_RS, CSR_OP_RSI: merge = MERGE_RS;
            CSR_OP_RC, CSR_OP_RCI: merge = MERGE_RC;
            default:               bad_op_s = 1'b1;
        endcase
`ifdef CSR_PRIV_CHECK_EN
        priv_bad_s = (addr_priv_bits > cur_priv);
`else
        priv_bad_s = 1'b0;
`endif
        // A set/clear with a zero source never writes, so it may target a read-only CSR.
        wr_raw_s = (merge == MERGE_RW) | ~rs1_zero;
        rd_raw_s = ~((merge == MERGE_RW) & rd_zero);
        illegal  = bad_op_s | priv_bad_s | (wr_raw_s & (addr_ro_bits == CSR_RO_PREFIX));
        do_read  = ~illegal & rd_raw_s;
        do_write = ~illegal & wr_raw_s;
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences Zicsr read/merge/write accesses on the single csrfile port and arbitrates
// it with trap-unit writes. Optional macro: CSR_PRIV_CHECK_EN (adds cur_priv input).
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              req_rd_zero,
    input  logic              req_rs1_zero,
`ifdef CSR_PRIV_CHECK_EN
    input  logic [1:0]        cur_priv,
`endif
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_illegal,
    input  logic              trap_req,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic [XLEN-1:0]   trap_wdata,
    output logic              trap_ack,
    output logic              csr_en,
    output logic              csr_read_en,
    output logic              csr_write_en,
    output logic [ADDR_W-1:0] csr_rsd,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata
);

    function automatic logic [XLEN-1:0] merge_value(input merge_e kind,
                                                    input logic [XLEN-1:0] old_v,
                                                    input logic [XLEN-1:0] src_v);
        logic [XLEN-1:0] res;
        case (kind)
            MERGE_RS: res = old_v | src_v;
            MERGE_RC: res = old_v & ~src_v;
            default:  res = src_v;
        endcase
        return res;
    endfunction

    state_t            state_q, state_d;
    merge_e            merge_q, merge_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              do_write_q, do_write_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic              alive_q;

    logic              csr_en_q, csr_en_d;
    logic              csr_read_en_q, csr_read_en_d;
    logic              csr_write_en_q, csr_write_en_d;
    logic [ADDR_W-1:0] csr_rsd_q, csr_rsd_d;
    logic [XLEN-1:0]   csr_wdata_q, csr_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_illegal_q, resp_illegal_d;
    logic              trap_ack_q, trap_ack_d;

    logic   dec_illegal_s;
    logic   dec_do_read_s;
    logic   dec_do_write_s;
    merge_e dec_merge_s;

    csr_op_decode u_decode (
        .op             (req_op),
        .addr_ro_bits   (req_addr[ADDR_W-1 -: 2]),
`ifdef CSR_PRIV_CHECK_EN
        .addr_priv_bits (req_addr[ADDR_W-3 -: 2]),
        .cur_priv       (cur_priv),
`endif
        .rd_zero        (req_rd_zero),
        .rs1_zero       (req_rs1_zero),
        .illegal        (dec_illegal_s),
        .do_read        (dec_do_read_s),
        .do_write       (dec_do_write_s),
        .merge          (dec_merge_s)
    );

    // req_ready stays low until the first clock after reset release.
    assign req_ready = alive_q & (state_q == ST_IDLE) & ~trap_req;

    // Next-state logic; csrfile and response outputs are computed for the state being entered.
    always_comb begin
        state_d        = state_q;
        merge_d        = merge_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        do_write_d     = do_write_q;
        old_d          = old_q;
        csr_en_d       = 1'b0;
        csr_read_en_d  = 1'b0;
        csr_write_en_d = 1'b0;
        csr_rsd_d      = {ADDR_W{1'b0}};
        csr_wdata_d    = {XLEN{1'b0}};
        resp_valid_d   = 1'b0;
        resp_rdata_d   = {XLEN{1'b0}};
        resp_illegal_d = 1'b0;
        trap_ack_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trap_req) begin
                    state_d        = ST_TWRITE;
                    csr_en_d       = 1'b1;
                    csr_write_en_d = 1'b1;
                    csr_rsd_d      = trap_addr;
                    csr_wdata_d    = trap_wdata;
                    trap_ack_d     = 1'b1;
                end else if (req_valid && alive_q) begin
                    merge_d    = dec_merge_s;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    do_write_d = dec_do_write_s;
                    old_d      = {XLEN{1'b0}};
                    if (dec_illegal_s) begin
                        state_d        = ST_RESP;
                        resp_valid_d   = 1'b1;
                        resp_illegal_d = 1'b1;
                    end else if (!dec_do_read_s) begin
                        state_d        = ST_WRITE;
                        csr_en_d       = 1'b1;
                        csr_write_en_d = 1'b1;
                        csr_rsd_d      = req_addr;
                        csr_wdata_d    = req_wdata;
                    end else begin
                        state_d       = ST_READ;
                        csr_en_d      = 1'b1;
                        csr_read_en_d = 1'b1;
                        csr_rsd_d     = req_addr;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: begin
                old_d = csr_rdata;
                if (do_write_q) begin
                    state_d        = ST_WRITE;
                    csr_en_d       = 1'b1;
                    csr_write_en_d = 1'b1;
                    csr_rsd_d      = addr_q;
                    csr_wdata_d    = merge_value(merge_q, csr_rdata, wdata_q);
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = csr_rdata;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = old_q;
            end
            ST_TWRITE: state_d = ST_IDLE;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, request context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            merge_q        <= MERGE_RW;
            addr_q         <= {ADDR_W{1'b0}};
            wdata_q        <= {XLEN{1'b0}};
            do_write_q     <= 1'b0;
            old_q          <= {XLEN{1'b0}};
            alive_q        <= 1'b0;
            csr_en_q       <= 1'b0;
            csr_read_en_q  <= 1'b0;
            csr_write_en_q <= 1'b0;
            csr_rsd_q      <= {ADDR_W{1'b0}};
            csr_wdata_q    <= {XLEN{1'b0}};
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= {XLEN{1'b0}};
            resp_illegal_q <= 1'b0;
            trap_ack_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            merge_q        <= merge_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            do_write_q     <= do_write_d;
            old_q          <= old_d;
            alive_q        <= 1'b1;
            csr_en_q       <= csr_en_d;
            csr_read_en_q  <= csr_read_en_d;
            csr_write_en_q <= csr_write_en_d;
            csr_rsd_q      <= csr_rsd_d;
            csr_wdata_q    <= csr_wdata_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_illegal_q <= resp_illegal_d;
            trap_ack_q     <= trap_ack_d;
        end
    end

    assign csr_en       = csr_en_q;
    assign csr_read_en  = csr_read_en_q;
    assign csr_write_en = csr_write_en_q;
    assign csr_rsd      = csr_rsd_q;
    assign csr_wdata    = csr_wdata_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_illegal = resp_illegal_q;
    assign trap_ack     = trap_ack_q;

endmodule
